// File: rtl/md_issue_ctrl_if.sv
// Start/op/busy handshake between the issue controller and the multiply/divide unit.
interface md_issue_ctrl_if;
  logic       md_start;
  logic [2:0] md_op;
  logic       md_busy;

  modport master (output md_start, output md_op, input md_busy);
  modport slave  (input md_start, input md_op, output md_busy);
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue/interlock controller for the multiply/divide unit: decodes the D-stage md class,
// drives a registered start/op into E, stalls F/D while a long op is outstanding.
module md_issue_ctrl #(
  parameter int unsigned STALL_CNT_W = 32,
  parameter int unsigned ISSUE_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   d_valid,
  input  logic [3:0]             d_md_op,
  input  logic                   e_flush,
  md_issue_ctrl_if.master        md,
  output logic                   stall_d,
  output logic                   e_is_md,
  output logic                   protocol_err,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [ISSUE_CNT_W-1:0] issue_cnt
);

  localparam int unsigned OP_W = 3;
  localparam logic [OP_W-1:0] OP_IDLE = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BUSY} state_t;

  state_t                 state_q, state_d;
  logic                   md_start_q, md_start_d;
  logic [OP_W-1:0]        md_op_q, md_op_d;
  logic                   e_is_md_q, e_is_md_d;
  logic                   perr_q, perr_d;
  logic                   first_busy_q, first_busy_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [ISSUE_CNT_W-1:0] issue_cnt_q, issue_cnt_d;

  logic            d_md, d_long, issue, issue_long;
  logic [OP_W-1:0] dec_op;

  // Class decode; unused classes look like "none".
  always_comb begin
    dec_op = OP_IDLE;
    d_long = 1'b0;
    d_md   = 1'b0;
    case (d_md_op)
      4'd1: begin dec_op = 3'b000; d_long = 1'b1; d_md = d_valid; end
      4'd2: begin dec_op = 3'b001; d_long = 1'b1; d_md = d_valid; end
      4'd3: begin dec_op = 3'b010; d_long = 1'b1; d_md = d_valid; end
      4'd4: begin dec_op = 3'b011; d_long = 1'b1; d_md = d_valid; end
      4'd5: begin dec_op = 3'b100; d_md = d_valid; end
      4'd6: begin dec_op = 3'b101; d_md = d_valid; end
      4'd7: begin dec_op = 3'b110; d_md = d_valid; end
      4'd8: begin dec_op = 3'b111; d_md = d_valid; end
      default: begin dec_op = OP_IDLE; d_long = 1'b0; d_md = 1'b0; end
    endcase
  end

  assign stall_d    = d_md && ((state_q == ST_START) || md.md_busy);
  assign issue      = d_md && !stall_d && !e_flush;
  assign issue_long = issue && d_long;

  // Next state, E-stage payload and statistics.
  always_comb begin
    state_d      = state_q;
    md_start_d   = 1'b0;
    md_op_d      = OP_IDLE;
    e_is_md_d    = 1'b0;
    perr_d       = perr_q;
    first_busy_d = (state_q == ST_START);
    stall_cnt_d  = stall_cnt_q;
    issue_cnt_d  = issue_cnt_q;

    if (issue) begin
      md_op_d    = dec_op;
      md_start_d = d_long;
      e_is_md_d  = 1'b1;
    end

    case (state_q)
      ST_IDLE:  if (issue_long) state_d = ST_START;
      ST_START: state_d = ST_BUSY;
      ST_BUSY:  if (!md.md_busy) state_d = issue_long ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Unit must have raised busy by the cycle after it saw start.
    if ((state_q == ST_BUSY) && first_busy_q && !md.md_busy) perr_d = 1'b1;

    if (stall_d && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    if (md_start_d)
      issue_cnt_d = issue_cnt_q + ISSUE_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      md_start_q   <= 1'b0;
      md_op_q      <= OP_IDLE;
      e_is_md_q    <= 1'b0;
      perr_q       <= 1'b0;
      first_busy_q <= 1'b0;
      stall_cnt_q  <= '0;
      issue_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      md_start_q   <= md_start_d;
      md_op_q      <= md_op_d;
      e_is_md_q    <= e_is_md_d;
      perr_q       <= perr_d;
      first_busy_q <= first_busy_d;
      stall_cnt_q  <= stall_cnt_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end

  assign md.md_start   = md_start_q;
  assign md.md_op      = md_op_q;
  assign e_is_md       = e_is_md_q;
  assign protocol_err  = perr_q;
  assign stall_cnt     = stall_cnt_q;
  assign issue_cnt     = issue_cnt_q;

endmodule
